vector_reg_file: RTL and testbench

//   Parametrised vector register file; successor to the single 16-lane latch register.

---
 rtl/vrf_pkg.sv | 38 +++
 rtl/vrf_read_port.sv | 80 ++++++++
 rtl/vector_reg_file.sv | 211 +++++++++++++++++++++
 tb/tb_vector_reg_file.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_pkg.sv
// -----------------------------------------------------------------------------
// vrf_pkg
//   Shared definitions for the vector register file:
//     - default width constants (lane width, lane count, register count)
//     - clear-sequencer state encoding
//     - lane_slice(): extracts one lane element from a flattened vector
// Ports: none (package).
// -----------------------------------------------------------------------------
package vrf_pkg;

    localparam int VRF_DATA_W   = 32;
    localparam int VRF_LANES    = 16;
    localparam int VRF_NUM_REGS = 8;

    // Upper bounds for lane_slice(); vectors are zero-extended to this width
    // before slicing, so DATA_W must not exceed VRF_MAX_DATA_W and
    // LANES*DATA_W must not exceed VRF_MAX_VEC_W.
    localparam int VRF_MAX_DATA_W = 64;
    localparam int VRF_MAX_VEC_W  = 4096;

    typedef enum logic [0:0] {
        VRF_IDLE  = 1'b0,
        VRF_CLEAR = 1'b1
    } vrf_state_e;

    // Returns lane 'lane' of a flattened vector whose lanes are data_w bits
    // wide. Bits above data_w in the result are don't-care; callers truncate.
    function automatic logic [VRF_MAX_DATA_W-1:0] lane_slice(
        input logic [VRF_MAX_VEC_W-1:0] vec,
        input int unsigned              lane,
        input int unsigned              data_w
    );
        logic [VRF_MAX_VEC_W-1:0] shifted;
        shifted = vec >> (lane * data_w);
        return shifted[VRF_MAX_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/vrf_read_port.sv
// -----------------------------------------------------------------------------
// vrf_read_port
//   One registered read port of the vector register file. Selects a register
//   from the array snapshot, merges in a same-cycle write (masked lanes take
//   the new data), forces zero for out-of-range addresses or the register
//   being cleared this cycle, and registers the result (1-cycle latency).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rd_en, rd_addr      read request and source register
//   regs                current contents of every register
//   wr_hit, wr_addr     a write to an in-range register lands on this edge
//   wr_mask, wr_lanes   lane enables and effective (post-broadcast) lane data
//   clr_active, clr_ptr register being zeroed on this edge
//   rd_data, rd_vld     registered read data and one-cycle valid pulse
// -----------------------------------------------------------------------------
module vrf_read_port
    import vrf_pkg::*;
#(
    parameter int DATA_W   = VRF_DATA_W,
    parameter int LANES    = VRF_LANES,
    parameter int NUM_REGS = VRF_NUM_REGS,
    parameter int ADDR_W   = $clog2(VRF_NUM_REGS),
    localparam int VEC_W   = LANES * DATA_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rd_en,
    input  logic [ADDR_W-1:0]                  rd_addr,
    input  logic [NUM_REGS-1:0][VEC_W-1:0]     regs,
    input  logic                               wr_hit,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [LANES-1:0]                   wr_mask,
    input  logic [VEC_W-1:0]                   wr_lanes,
    input  logic                               clr_active,
    input  logic [ADDR_W-1:0]                  clr_ptr,
    output logic [VEC_W-1:0]                   rd_data,
    output logic                               rd_vld
);

    logic [VEC_W-1:0] merged_s;
    logic             addr_ok_s;

    assign addr_ok_s = (32'(rd_addr) < 32'(NUM_REGS));

    // Read mux with write-through and clear bypass.
    always_comb begin
        merged_s = '0;
        if (!addr_ok_s) begin
            merged_s = '0;
        end else if (clr_active && (rd_addr == clr_ptr)) begin
            merged_s = '0;
        end else if (wr_hit && (wr_addr == rd_addr)) begin
            merged_s = regs[rd_addr];
            for (int l = 0; l < LANES; l++) begin
                if (wr_mask[l]) begin
                    merged_s[l*DATA_W +: DATA_W] =
                        DATA_W'(lane_slice(VRF_MAX_VEC_W'(wr_lanes), l, DATA_W));
                end else begin
                    merged_s[l*DATA_W +: DATA_W] = regs[rd_addr][l*DATA_W +: DATA_W];
                end
            end
        end else begin
            merged_s = regs[rd_addr];
        end
    end

    // Output register: data holds when no request, valid pulses per request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                rd_data <= merged_s;
            end
        end
    end

endmodule

// File: rtl/vector_reg_file.sv
// -----------------------------------------------------------------------------
// vector_reg_file
//   NUM_REGS vector registers of LANES x DATA_W with one lane-masked write
//   port (valid/ready), two registered read ports, a per-register pending
//   scoreboard and a multi-cycle clear sequencer (one register per cycle).
// Configuration macro:
//   VRF_BCAST_EN  adds wr_bcast; when set, wr_data lane 0 is written into
//                 every masked lane (and seen by the read bypass).
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   wr_valid/wr_ready               write handshake (ready low while clearing)
//   wr_addr, wr_mask, wr_data       destination, lane enables, lane data
//   wr_bcast                        broadcast lane 0 (VRF_BCAST_EN only)
//   rd_en_a/b, rd_addr_a/b          read requests
//   rd_data_a/b, rd_vld_a/b         registered read data and valid
//   rsv_en, rsv_addr                mark a register pending
//   pending                         scoreboard, bit r = write outstanding
//   clr_start, busy                 start / in-progress of the clear sequence
// -----------------------------------------------------------------------------
module vector_reg_file
    import vrf_pkg::*;
#(
    parameter int DATA_W   = VRF_DATA_W,
    parameter int LANES    = VRF_LANES,
    parameter int NUM_REGS = VRF_NUM_REGS,
    localparam int ADDR_W  = $clog2(NUM_REGS),
    localparam int VEC_W   = LANES * DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [LANES-1:0]    wr_mask,
    input  logic [VEC_W-1:0]    wr_data,
`ifdef VRF_BCAST_EN
    input  logic                wr_bcast,
`endif
    input  logic                rd_en_a,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    output logic [VEC_W-1:0]    rd_data_a,
    output logic                rd_vld_a,
    input  logic                rd_en_b,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [VEC_W-1:0]    rd_data_b,
    output logic                rd_vld_b,
    input  logic                rsv_en,
    input  logic [ADDR_W-1:0]   rsv_addr,
    output logic [NUM_REGS-1:0] pending,
    input  logic                clr_start,
    output logic                busy
);

    vrf_state_e                     state_r;
    logic [ADDR_W-1:0]              clr_ptr_r;
    logic                           busy_r;
    logic                           wr_ready_r;
    logic [NUM_REGS-1:0]            pending_r;
    logic [NUM_REGS-1:0]            pending_nxt_s;
    logic [NUM_REGS-1:0][VEC_W-1:0] regs_r;
    logic [VEC_W-1:0]               wr_lanes_s;
    logic                           wr_hit_s;
    logic                           rsv_set_s;
    logic                           clr_go_s;
    logic                           clr_active_s;

    // An out-of-range write is still accepted but touches nothing.
    assign wr_hit_s     = wr_valid && wr_ready_r && (32'(wr_addr) < 32'(NUM_REGS));
    assign clr_active_s = (state_r == VRF_CLEAR);
    assign clr_go_s     = clr_start && (state_r == VRF_IDLE);
    assign rsv_set_s    = rsv_en && !clr_active_s && (32'(rsv_addr) < 32'(NUM_REGS));

    assign wr_ready = wr_ready_r;
    assign busy     = busy_r;
    assign pending  = pending_r;

    // Effective write lanes: own slice, or lane 0 replicated when broadcasting.
    always_comb begin
        wr_lanes_s = wr_data;
`ifdef VRF_BCAST_EN
        if (wr_bcast) begin
            for (int l = 0; l < LANES; l++) begin
                wr_lanes_s[l*DATA_W +: DATA_W] =
                    DATA_W'(lane_slice(VRF_MAX_VEC_W'(wr_data), 0, DATA_W));
            end
        end else begin
            wr_lanes_s = wr_data;
        end
`endif
    end

    // Clear sequencer; busy/wr_ready are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= VRF_IDLE;
            clr_ptr_r  <= '0;
            busy_r     <= 1'b0;
            wr_ready_r <= 1'b1;
        end else begin
            case (state_r)
                VRF_IDLE: begin
                    if (clr_start) begin
                        state_r    <= VRF_CLEAR;
                        clr_ptr_r  <= '0;
                        busy_r     <= 1'b1;
                        wr_ready_r <= 1'b0;
                    end
                end
                VRF_CLEAR: begin
                    if (clr_ptr_r == ADDR_W'(NUM_REGS - 1)) begin
                        state_r    <= VRF_IDLE;
                        clr_ptr_r  <= '0;
                        busy_r     <= 1'b0;
                        wr_ready_r <= 1'b1;
                    end else begin
                        clr_ptr_r  <= clr_ptr_r + ADDR_W'(1);
                    end
                end
                default: begin
                    state_r    <= VRF_IDLE;
                    clr_ptr_r  <= '0;
                    busy_r     <= 1'b0;
                    wr_ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Register array: clearing and writing never coincide (wr_ready is low).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_r <= '0;
        end else if (clr_active_s) begin
            regs_r[clr_ptr_r] <= '0;
        end else if (wr_hit_s) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_mask[l]) begin
                    regs_r[wr_addr][l*DATA_W +: DATA_W] <= wr_lanes_s[l*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Scoreboard next state: clear start wins, then reserve over write-clear.
    always_comb begin
        pending_nxt_s = pending_r;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (clr_go_s) begin
                pending_nxt_s[r] = 1'b0;
            end else if (rsv_set_s && (32'(rsv_addr) == 32'(r))) begin
                pending_nxt_s[r] = 1'b1;
            end else if (wr_hit_s && (32'(wr_addr) == 32'(r))) begin
                pending_nxt_s[r] = 1'b0;
            end else begin
                pending_nxt_s[r] = pending_r[r];
            end
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= '0;
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    vrf_read_port #(
        .DATA_W   (DATA_W),
        .LANES    (LANES),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_port_a (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en_a),
        .rd_addr    (rd_addr_a),
        .regs       (regs_r),
        .wr_hit     (wr_hit_s),
        .wr_addr    (wr_addr),
        .wr_mask    (wr_mask),
        .wr_lanes   (wr_lanes_s),
        .clr_active (clr_active_s),
        .clr_ptr    (clr_ptr_r),
        .rd_data    (rd_data_a),
        .rd_vld     (rd_vld_a)
    );

    vrf_read_port #(
        .DATA_W   (DATA_W),
        .LANES    (LANES),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_port_b (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en_b),
        .rd_addr    (rd_addr_b),
        .regs       (regs_r),
        .wr_hit     (wr_hit_s),
        .wr_addr    (wr_addr),
        .wr_mask    (wr_mask),
        .wr_lanes   (wr_lanes_s),
        .clr_active (clr_active_s),
        .clr_ptr    (clr_ptr_r),
        .rd_data    (rd_data_b),
        .rd_vld     (rd_vld_b)
    );

endmodule

// File: tb/tb_vector_reg_file.sv
// -----------------------------------------------------------------------------
// tb_vector_reg_file
//   Directed self-checking bench for vector_reg_file, built with six
//   registers so that addresses 6 and 7 exercise the out-of-range rules.
//   Broadcast vectors run only when VRF_BCAST_EN is defined.
// -----------------------------------------------------------------------------
module tb_vector_reg_file;

    localparam int DW = 32;
    localparam int LN = 16;
    localparam int NR = 6;
    localparam int AW = 3;
    localparam int VW = DW * LN;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [LN-1:0] wr_mask;
    logic [VW-1:0] wr_data;
`ifdef VRF_BCAST_EN
    logic          wr_bcast;
`endif
    logic          rd_en_a;
    logic [AW-1:0] rd_addr_a;
    logic [VW-1:0] rd_data_a;
    logic          rd_vld_a;
    logic          rd_en_b;
    logic [AW-1:0] rd_addr_b;
    logic [VW-1:0] rd_data_b;
    logic          rd_vld_b;
    logic          rsv_en;
    logic [AW-1:0] rsv_addr;
    logic [NR-1:0] pending;
    logic          clr_start;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vector_reg_file #(.DATA_W(DW), .LANES(LN), .NUM_REGS(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_mask   (wr_mask),
        .wr_data   (wr_data),
`ifdef VRF_BCAST_EN
        .wr_bcast  (wr_bcast),
`endif
        .rd_en_a   (rd_en_a),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_vld_a  (rd_vld_a),
        .rd_en_b   (rd_en_b),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .rd_vld_b  (rd_vld_b),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .pending   (pending),
        .clr_start (clr_start),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] splat(input logic [DW-1:0] v);
        logic [VW-1:0] r;
        for (int l = 0; l < LN; l++) r[l*DW +: DW] = v;
        return r;
    endfunction

    task automatic idle_inputs();
        wr_valid = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
`ifdef VRF_BCAST_EN
        wr_bcast = 1'b0;
`endif
        rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0;
        rsv_en = 1'b0; rsv_addr = '0; clr_start = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [LN-1:0] m, input logic [VW-1:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_mask = m; wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_read_a(input logic [AW-1:0] a);
        rd_en_a = 1'b1; rd_addr_a = a;
        tick();
        rd_en_a = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [VW-1:0] d;
        logic [VW-1:0] exp;
        int n;

        // Reset state
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        check_eq("rst_pending",  VW'(pending),  '0);
        check_eq("rst_rd_vld_a", VW'(rd_vld_a), '0);
        check_eq("rst_wr_ready", VW'(wr_ready), VW'(1));
        check_eq("rst_busy",     VW'(busy),     '0);
        check_eq("rst_rd_data",  rd_data_a,     '0);
        rst = 1'b0;
        tick();

        // Read of an untouched register returns zero with one valid pulse
        do_read_a(3'd3);
        check_eq("r3_vld",  VW'(rd_vld_a), VW'(1));
        check_eq("r3_data", rd_data_a,     '0);
        tick();
        check_eq("r3_vld_drop", VW'(rd_vld_a), '0);

        // Masked write: lanes 0-7 = 1..8, lanes 8-15 stay zero
        for (int l = 0; l < LN; l++) d[l*DW +: DW] = DW'(l + 1);
        do_write(3'd2, 16'h00FF, d);
        exp = '0;
        for (int l = 0; l < 8; l++) exp[l*DW +: DW] = DW'(l + 1);
        rd_en_b = 1'b1; rd_addr_b = 3'd2;
        tick();
        rd_en_b = 1'b0;
        check_eq("r2_mask_data", rd_data_b,     exp);
        check_eq("r2_mask_vld",  VW'(rd_vld_b), VW'(1));
        tick();
        check_eq("r2_hold_data", rd_data_b,     exp);
        check_eq("r2_hold_vld",  VW'(rd_vld_b), '0);

        // Write-through bypass: lane 0 new, lanes 1-15 old, both ports
        do_write(3'd5, 16'hFFFF, splat(32'h1111_1111));
        d = splat(32'hFFFF_FFFF);
        d[DW-1:0] = 32'h0000_DEAD;
        wr_valid = 1'b1; wr_addr = 3'd5; wr_mask = 16'h0001; wr_data = d;
        rd_en_a = 1'b1; rd_addr_a = 3'd5;
        rd_en_b = 1'b1; rd_addr_b = 3'd5;
        tick();
        idle_inputs();
        exp = splat(32'h1111_1111);
        exp[DW-1:0] = 32'h0000_DEAD;
        check_eq("r5_bypass_a", rd_data_a, exp);
        check_eq("r5_bypass_b", rd_data_b, exp);
        do_read_a(3'd5);
        check_eq("r5_stored", rd_data_a, exp);

        // Scoreboard
        rsv_en = 1'b1; rsv_addr = 3'd4;
        tick();
        rsv_en = 1'b0;
        check_eq("rsv_r4", VW'(pending), VW'(6'h10));
        do_write(3'd4, 16'h0000, splat(32'h0000_0001));
        check_eq("wr_mask0_clears", VW'(pending), '0);
        do_read_a(3'd4);
        check_eq("wr_mask0_nodata", rd_data_a, '0);
        rsv_en = 1'b1; rsv_addr = 3'd4;
        wr_valid = 1'b1; wr_addr = 3'd4; wr_mask = 16'hFFFF; wr_data = splat(32'h44);
        tick();
        idle_inputs();
        check_eq("rsv_wr_same", VW'(pending), VW'(6'h10));
        do_write(3'd4, 16'hFFFF, splat(32'h44));
        check_eq("wr_r4_clears", VW'(pending), '0);

        // Out-of-range: write accepted and dropped, read zero, reserve ignored
        check_eq("oor_ready", VW'(wr_ready), VW'(1));
        wr_valid = 1'b1; wr_addr = 3'd7; wr_mask = 16'hFFFF; wr_data = splat(32'h77);
        rsv_en = 1'b1; rsv_addr = 3'd6;
        tick();
        idle_inputs();
        check_eq("oor_rsv", VW'(pending), '0);
        rd_en_a = 1'b1; rd_addr_a = 3'd7; rd_en_b = 1'b1; rd_addr_b = 3'd6;
        tick();
        idle_inputs();
        check_eq("oor_vld_a",  VW'(rd_vld_a), VW'(1));
        check_eq("oor_data_a", rd_data_a,     '0);
        check_eq("oor_data_b", rd_data_b,     '0);

        // Clear sequence
        for (int r = 0; r < NR; r++) do_write(AW'(r), 16'hFFFF, splat(DW'(r + 1)));
        rsv_en = 1'b1; rsv_addr = 3'd1;
        tick();
        rsv_en = 1'b0;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check_eq("clr_busy",     VW'(busy),     VW'(1));
        check_eq("clr_ready",    VW'(wr_ready), '0);
        check_eq("clr_pending",  VW'(pending),  '0);
        // first clearing cycle: r0 being cleared, r3 not yet
        rd_en_a = 1'b1; rd_addr_a = 3'd0; rd_en_b = 1'b1; rd_addr_b = 3'd3;
        rsv_en = 1'b1; rsv_addr = 3'd2;
        tick();
        n = 1;
        idle_inputs();
        check_eq("clr_rd_r0",  rd_data_a,    '0);
        check_eq("clr_rd_r3",  rd_data_b,    splat(32'h4));
        check_eq("clr_rsv",    VW'(pending), '0);
        clr_start = 1'b1;
        tick();
        n++;
        clr_start = 1'b0;
        while (busy && n < 20) begin
            check_eq("clr_ready_low", VW'(wr_ready), '0);
            tick();
            n++;
        end
        check_eq("clr_cycles",   VW'(n),        VW'(NR));
        check_eq("clr_ready_up", VW'(wr_ready), VW'(1));
        for (int r = 0; r < NR; r++) begin
            do_read_a(AW'(r));
            check_eq("clr_zero", rd_data_a, '0);
        end

        // Reset in the middle of a clear
        do_write(3'd2, 16'hFFFF, splat(32'h55));
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        tick();
        check_eq("mid_busy", VW'(busy), VW'(1));
        rst = 1'b1;
        #1;
        check_eq("rst_mid_busy",  VW'(busy),     '0);
        check_eq("rst_mid_ready", VW'(wr_ready), VW'(1));
        #3;
        rst = 1'b0;
        tick();
        do_read_a(3'd2);
        check_eq("rst_mid_r2", rd_data_a, '0);

`ifdef VRF_BCAST_EN
        // Broadcast lane 0 into lanes 4-7 and 12-15
        for (int l = 0; l < LN; l++) d[l*DW +: DW] = 32'hAAAA_0000 + DW'(l);
        do_write(3'd1, 16'hFFFF, d);
        exp = d;
        d = splat(32'hFFFF_FFFF);
        d[DW-1:0] = 32'h0000_1234;
        wr_valid = 1'b1; wr_addr = 3'd1; wr_mask = 16'hF0F0; wr_data = d; wr_bcast = 1'b1;
        rd_en_a = 1'b1; rd_addr_a = 3'd1;
        tick();
        idle_inputs();
        for (int l = 4; l < 8; l++)   exp[l*DW +: DW] = 32'h0000_1234;
        for (int l = 12; l < 16; l++) exp[l*DW +: DW] = 32'h0000_1234;
        check_eq("bcast_bypass", rd_data_a, exp);
        do_read_a(3'd1);
        check_eq("bcast_stored", rd_data_a, exp);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
